// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - MMIO register front-end with TX/RX byte FIFOs for a UART
module uart_mmio_ctrl #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mmio_addr,
    input  logic        mmio_re,
    input  logic        mmio_we,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] SEL_STATUS = 2'd0;
    localparam logic [1:0] SEL_RXDATA = 2'd1;
    localparam logic [1:0] SEL_TXDATA = 2'd2;
    localparam logic [1:0] SEL_CTRL   = 2'd3;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic        rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  reg_sel;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_push_req, tx_pop, tx_push, tx_ovf_evt;
    logic        rx_push_req, rx_pop, rx_push, rx_ovf_evt;
    logic        ctrl_we, ovf_clr;
    logic [31:0] status_word;
    logic        unused_bits;

    assign reg_sel     = mmio_addr[3:2];
    assign unused_bits = &{1'b0, mmio_addr[1:0], mmio_wdata[31:8]};

    // Full means same slot index but one lap apart; empty means identical pointers.
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign tx_push_req = mmio_we && (reg_sel == SEL_TXDATA);
    assign tx_pop      = !tx_empty && uart_tx_ready;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_ovf_evt  = tx_push_req && tx_full && !tx_pop;

    assign rx_push_req = uart_rx_valid;
    assign rx_pop      = mmio_re && (reg_sel == SEL_RXDATA) && !rx_empty;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign rx_ovf_evt  = rx_push_req && rx_full && !rx_pop;

    assign ctrl_we = mmio_we && (reg_sel == SEL_CTRL);
    assign ovf_clr = ctrl_we && mmio_wdata[2];

    assign status_word = {27'd0, tx_empty, tx_ovf_q, rx_ovf_q, !rx_empty, !tx_full};

    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_q[AW-1:0]];
    assign uart_rx_ready = 1'b1;
    assign mmio_rdata    = rdata_q;
    assign irq           = (rx_irq_en_q && !rx_empty) || (tx_irq_en_q && tx_empty);

    // Next-state for pointers, sticky flags (new event wins over clear), enables and read data.
    always_comb begin
        tx_wr_d     = tx_wr_q;
        tx_rd_d     = tx_rd_q;
        rx_wr_d     = rx_wr_q;
        rx_rd_d     = rx_rd_q;
        tx_ovf_d    = (tx_ovf_q && !ovf_clr) || tx_ovf_evt;
        rx_ovf_d    = (rx_ovf_q && !ovf_clr) || rx_ovf_evt;
        rx_irq_en_d = rx_irq_en_q;
        tx_irq_en_d = tx_irq_en_q;
        rdata_d     = rdata_q;
        if (tx_push) tx_wr_d = tx_wr_q + PTR_ONE;
        if (tx_pop)  tx_rd_d = tx_rd_q + PTR_ONE;
        if (rx_push) rx_wr_d = rx_wr_q + PTR_ONE;
        if (rx_pop)  rx_rd_d = rx_rd_q + PTR_ONE;
        if (ctrl_we) begin
            rx_irq_en_d = mmio_wdata[0];
            tx_irq_en_d = mmio_wdata[1];
        end
        if (mmio_re) begin
            case (reg_sel)
                SEL_STATUS: rdata_d = status_word;
                SEL_RXDATA: rdata_d = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_q[AW-1:0]]};
                SEL_CTRL:   rdata_d = {30'd0, tx_irq_en_q, rx_irq_en_q};
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_ovf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
            rx_irq_en_q <= 1'b0;
            tx_irq_en_q <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_ovf_q    <= rx_ovf_d;
            rx_irq_en_q <= rx_irq_en_d;
            tx_irq_en_q <= tx_irq_en_d;
            rdata_q     <= rdata_d;
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= mmio_wdata[7:0];
        if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= uart_rx_data;
    end
endmodule
